instr_assembler: RTL and testbench

Instruction assembler and program loader for the single-cycle RV32I core. It accepts one decoded instruction description per handshake: operation class, register indices, funct fields and a signed immediate. It packs these into a 32-bit RV32I word and writes the words sequentially into instruction memory. It encodes the same opcode set that the main control decoder interprets (R, I-ALU, load, store, branch, JAL, JALR), so self-test and bring-up programs can be built in hardware.

---
 rtl/rv_isa_pkg.sv | 42 ++++
 rtl/instr_assembler_if.sv | 26 ++
 rtl/instr_field_pack.sv | 56 +++++
 rtl/instr_assembler.sv | 119 +++++++++++
 tb/tb_instr_assembler.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants, instruction-class and FSM enums, and immediate range limits
// shared by the instruction assembler and the core's control decoder.
package rv_isa_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_JAL     = 3'd5,
    CLS_JALR    = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_e;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FULL  = 2'd1,
    ST_ERROR = 2'd2
  } asm_state_e;

  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  localparam int signed IMM_B_MIN = -4096;
  localparam int signed IMM_B_MAX = 4094;
  localparam int signed IMM_J_MIN = -1048576;
  localparam int signed IMM_J_MAX = 1048574;

  function automatic logic imm_in_range(input logic [31:0] imm, input int signed lo,
                                        input int signed hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/instr_assembler_if.sv
// Instruction-description handshake between a program source (master) and the
// instruction assembler (slave).
interface instr_assembler_if;
  import rv_isa_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;

  modport master (
    output in_valid, in_class, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_class, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready
  );

endinterface

// File: rtl/instr_field_pack.sv
// Combinational RV32I word packer: class, fields and immediate in; 32-bit word and range_ok out.
// Optional ASM_RANGE_CHECK_EN flags immediates that do not fit their format.
module instr_field_pack
  import rv_isa_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_ok
);

  instr_class_e cls_e;
  assign cls_e = instr_class_e'(cls);

  always_comb begin
    word = '0;
    case (cls_e)
      CLS_R:      word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OPC_R};
      CLS_I:      word = {imm[11:0], rs1, funct3, rd, OPC_I};
      CLS_LOAD:   word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      CLS_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      CLS_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
      CLS_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      // JALR has a single valid funct3, so the supplied one is ignored
      CLS_JALR:   word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
      default:    word = '0;
    endcase
  end

`ifdef ASM_RANGE_CHECK_EN
  always_comb begin
    range_ok = 1'b1;
    case (cls_e)
      CLS_I, CLS_LOAD, CLS_STORE, CLS_JALR:
        range_ok = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
      CLS_BRANCH:
        range_ok = imm_in_range(imm, IMM_B_MIN, IMM_B_MAX) && !imm[0];
      CLS_JAL:
        range_ok = imm_in_range(imm, IMM_J_MIN, IMM_J_MAX) && !imm[0];
      default:
        range_ok = 1'b1;
    endcase
  end
`else
  assign range_ok = 1'b1;

  logic unused_imm_bits;
  assign unused_imm_bits = ^imm[31:21];
`endif

endmodule

// File: rtl/instr_assembler.sv
// RV32I instruction assembler / program loader: encodes one description per handshake and
// writes it to sequential imem words. Build with ASM_RANGE_CHECK_EN to reject out-of-range immediates.
module instr_assembler
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  instr_assembler_if.slave  in_if,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0] LAST_COUNT = {1'b0, {ADDR_W{1'b1}}};

  asm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              full_q, full_d;
  logic              err_q, err_d;

  logic [31:0] packed_word;
  logic        range_ok;
  logic        handshake;
  logic        bad_desc;

  instr_field_pack u_pack (
    .cls      (in_if.in_class),
    .funct3   (in_if.in_funct3),
    .funct7b5 (in_if.in_funct7b5),
    .rd       (in_if.in_rd),
    .rs1      (in_if.in_rs1),
    .rs2      (in_if.in_rs2),
    .imm      (in_if.in_imm),
    .word     (packed_word),
    .range_ok (range_ok)
  );

  assign in_if.in_ready = (state_q == ST_LOAD) && !clear;
  assign handshake      = in_if.in_valid && in_if.in_ready;
  assign bad_desc       = (instr_class_e'(in_if.in_class) == CLS_ILLEGAL) || !range_ok;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    full_d  = full_q;
    err_d   = err_q;

    if (clear) begin
      state_d = ST_LOAD;
      ptr_d   = '0;
      count_d = '0;
      addr_d  = '0;
      wdata_d = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else if (handshake) begin
      if (bad_desc) begin
        err_d   = 1'b1;
        state_d = ST_ERROR;
      end else begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = packed_word;
        count_d = count_q + 1'b1;
        // The last slot parks the pointer instead of wrapping it back to word 0
        if (count_q == LAST_COUNT) begin
          full_d  = 1'b1;
          state_d = ST_FULL;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      ptr_q   <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign full       = full_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_assembler.sv
// Directed self-checking bench for instr_assembler (ADDR_W=2, four-word memory);
// expected encodings are hand-computed RV32I words.
module tb_instr_assembler;

  localparam int ADDR_W = 2;

  logic              clk;
  logic              rst;
  logic              clear;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  int total;
  int bad;

  instr_assembler_if ifc ();

  instr_assembler #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_if      (ifc),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .full       (full),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic r, input logic c, input logic v, input logic [2:0] cls,
                               input logic [2:0] f3, input logic b5, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    rst             = r;
    clear           = c;
    ifc.in_valid    = v;
    ifc.in_class    = cls;
    ifc.in_funct3   = f3;
    ifc.in_funct7b5 = b5;
    ifc.in_rd       = rd;
    ifc.in_rs1      = rs1;
    ifc.in_rs2      = rs2;
    ifc.in_imm      = imm;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_class = 3'd0;
    ifc.in_funct3 = 3'd0;
    ifc.in_funct7b5 = 1'b0;
    ifc.in_rd = 5'd0;
    ifc.in_rs1 = 5'd0;
    ifc.in_rs2 = 5'd0;
    ifc.in_imm = 32'd0;

    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    idle();
    checkOutput("rst_we", 32'(imem_we), 32'd0);
    checkOutput("rst_addr", 32'(imem_addr), 32'd0);
    checkOutput("rst_wdata", imem_wdata, 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_ready", 32'(ifc.in_ready), 32'd1);

    // addi x1,x0,5, gap, addi again, then clear while the second write is on the bus
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    checkOutput("addi_we", 32'(imem_we), 32'd1);
    checkOutput("addi_addr", 32'(imem_addr), 32'd0);
    checkOutput("addi_wdata", imem_wdata, 32'h00500093);
    checkOutput("addi_count", 32'(count), 32'd1);
    idle();
    checkOutput("we_one_cycle", 32'(imem_we), 32'd0);
    checkOutput("wdata_hold", imem_wdata, 32'h00500093);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    checkOutput("addi2_addr", 32'(imem_addr), 32'd1);
    checkOutput("addi2_count", 32'(count), 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    checkOutput("clr_we", 32'(imem_we), 32'd0);
    checkOutput("clr_count", 32'(count), 32'd0);
    checkOutput("clr_wdata", imem_wdata, 32'd0);
    checkOutput("clr_addr", 32'(imem_addr), 32'd0);

    // Five back-to-back beats into a four-word memory
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    checkOutput("add_we", 32'(imem_we), 32'd1);
    checkOutput("add_addr", 32'(imem_addr), 32'd0);
    checkOutput("add_wdata", imem_wdata, 32'h002081B3);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
    checkOutput("sub_we", 32'(imem_we), 32'd1);
    checkOutput("sub_addr", 32'(imem_addr), 32'd1);
    checkOutput("sub_wdata", imem_wdata, 32'h402081B3);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    checkOutput("sw_addr", 32'(imem_addr), 32'd2);
    checkOutput("sw_wdata", imem_wdata, 32'h0020A423);
    checkOutput("sw_full", 32'(full), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
    checkOutput("jal_addr", 32'(imem_addr), 32'd3);
    checkOutput("jal_wdata", imem_wdata, 32'h008000EF);
    checkOutput("jal_count", 32'(count), 32'd4);
    checkOutput("jal_full", 32'(full), 32'd1);
    checkOutput("full_ready", 32'(ifc.in_ready), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    checkOutput("beat5_we", 32'(imem_we), 32'd0);
    checkOutput("beat5_count", 32'(count), 32'd4);
    checkOutput("beat5_addr", 32'(imem_addr), 32'd3);

    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    idle();
    checkOutput("clr_full", 32'(full), 32'd0);
    checkOutput("clr_ready", 32'(ifc.in_ready), 32'd1);

    // Branch, negative-immediate load, and JALR with a stray funct3
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd4, 3'd1, 1'b0, 5'd0, 5'd1, 5'd2, 32'd16);
    checkOutput("bne_wdata", imem_wdata, 32'h00209863);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF8);
    checkOutput("beq_neg_wdata", imem_wdata, 32'hFE000CE3);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd2, 3'd2, 1'b0, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFC);
    checkOutput("lw_wdata", imem_wdata, 32'hFFC12283);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd6, 3'd7, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0);
    checkOutput("jalr_wdata", imem_wdata, 32'h00008067);
    checkOutput("jalr_addr", 32'(imem_addr), 32'd3);

    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    idle();

    // clear and in_valid together: clear wins
    clear        = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.in_class = 3'd1;
    #1;
    checkOutput("clr_valid_ready", 32'(ifc.in_ready), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    checkOutput("clr_valid_we", 32'(imem_we), 32'd0);
    checkOutput("clr_valid_count", 32'(count), 32'd0);

    // Illegal class after one good write
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    checkOutput("pre_ill_we", 32'(imem_we), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    checkOutput("ill_we", 32'(imem_we), 32'd0);
    checkOutput("ill_err", 32'(err), 32'd1);
    checkOutput("ill_ready", 32'(ifc.in_ready), 32'd0);
    checkOutput("ill_count", 32'(count), 32'd1);
    checkOutput("ill_wdata_hold", imem_wdata, 32'h00500093);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    checkOutput("errst_we", 32'(imem_we), 32'd0);
    checkOutput("errst_count", 32'(count), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    idle();
    checkOutput("errclr_err", 32'(err), 32'd0);
    checkOutput("errclr_ready", 32'(ifc.in_ready), 32'd1);
    checkOutput("errclr_count", 32'(count), 32'd0);

    // addi with imm=2048: rejected with range checking, truncated without
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
`ifdef ASM_RANGE_CHECK_EN
    checkOutput("range_we", 32'(imem_we), 32'd0);
    checkOutput("range_err", 32'(err), 32'd1);
    checkOutput("range_ready", 32'(ifc.in_ready), 32'd0);
    checkOutput("range_count", 32'(count), 32'd0);
`else
    checkOutput("trunc_we", 32'(imem_we), 32'd1);
    checkOutput("trunc_wdata", imem_wdata, 32'h80000093);
    checkOutput("trunc_err", 32'(err), 32'd0);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    idle();
    checkOutput("range_clr_err", 32'(err), 32'd0);
    checkOutput("range_clr_count", 32'(count), 32'd0);

    // rst in the middle of a stream
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    checkOutput("stream_we", 32'(imem_we), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
    checkOutput("midrst_we", 32'(imem_we), 32'd0);
    checkOutput("midrst_addr", 32'(imem_addr), 32'd0);
    checkOutput("midrst_wdata", imem_wdata, 32'd0);
    checkOutput("midrst_count", 32'(count), 32'd0);
    checkOutput("midrst_full", 32'(full), 32'd0);
    checkOutput("midrst_err", 32'(err), 32'd0);
    idle();
    checkOutput("postrst_ready", 32'(ifc.in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
